// File: rtl/lock_code_sender_pkg.sv
// Shared widths for the lock code sender: symbol width and counter sizes.
// The counters are sized so that every legal WAIT_CYCLES/MAX_TRIES value fits without wrapping.
package lock_code_sender_pkg;

  localparam int SYM_W      = 3;
  localparam int WAIT_CNT_W = 4;
  localparam int TRY_CNT_W  = 3;

  typedef logic [SYM_W-1:0] sym_t;

endpackage

// File: rtl/lock_code_sender.sv
// Sends the three-symbol unlock code to a digital lock, waits a bounded window for its
// y response, and retries up to MAX_TRIES times before reporting failure.
module lock_code_sender
  import lock_code_sender_pkg::*;
#(
  parameter logic [2:0] C1          = 3'b011,
  parameter logic [2:0] C2          = 3'b111,
  parameter logic [2:0] C3          = 3'b101,
  parameter logic [2:0] IDLE_SYM    = 3'b000,
  parameter int         WAIT_CYCLES = 4,
  parameter int         MAX_TRIES   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [SYM_W-1:0] x_out,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic             unlocked,
  output logic             fail
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND1 = 3'd1;
  localparam logic [2:0] S_SEND2 = 3'd2;
  localparam logic [2:0] S_SEND3 = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES - 1);
  localparam logic [TRY_CNT_W-1:0]  TRY_LIMIT = TRY_CNT_W'(MAX_TRIES);

  logic [2:0]            state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [TRY_CNT_W-1:0]  try_cnt;

  assign busy = (state != S_IDLE);

  // NOTE: all state below is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      x_out    <= IDLE_SYM;
      wait_cnt <= '0;
      try_cnt  <= '0;
      done     <= 1'b0;
      unlocked <= 1'b0;
      fail     <= 1'b0;
    end else begin
      // NOTE: done and x_out get a default every cycle, so each branch only states
      // where they differ and neither can hold a stale value.
      done  <= 1'b0;
      x_out <= IDLE_SYM;

      if (abort) begin
        // Cancel silently: the result flags keep whatever they held.
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state    <= S_SEND1;
              x_out    <= C1;
              unlocked <= 1'b0;
              fail     <= 1'b0;
              try_cnt  <= TRY_CNT_W'(1);
            end
          end
          S_SEND1: begin
            state <= S_SEND2;
            x_out <= C2;
          end
          S_SEND2: begin
            state <= S_SEND3;
            x_out <= C3;
          end
          S_SEND3: begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
          S_WAIT: begin
            // A response on the last window sample still counts as success.
            if (y_in) begin
              state    <= S_FIN;
              unlocked <= 1'b1;
              done     <= 1'b1;
            end else if (wait_cnt == WAIT_LAST) begin
              if (try_cnt < TRY_LIMIT) begin
                state <= S_GAP;
              end else begin
                state <= S_FIN;
                fail  <= 1'b1;
                done  <= 1'b1;
              end
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          S_GAP: begin
            state   <= S_SEND1;
            x_out   <= C1;
            try_cnt <= try_cnt + 1'b1;
          end
          S_FIN: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/lock_code_sender.md
LOCK_CODE_SENDER -- requirements
Module: lock_code_sender

Interface
REQ-001 SHALL have parameter C1, default 3'b011, first code symbol.
REQ-002 SHALL have parameter C2, default 3'b111, second code symbol.
REQ-003 SHALL have parameter C3, default 3'b101, third code symbol.
REQ-004 SHALL have parameter IDLE_SYM, default 3'b000, symbol driven when not sending; must differ from C1.
REQ-005 SHALL have parameter WAIT_CYCLES, default 4, number of response-window samples (range 2..15).
REQ-006 SHALL have parameter MAX_TRIES, default 3, total send attempts before failure (range 1..7).
REQ-007 SHALL have port clk  input  1  single clock, rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port start  input  1  request an unlock sequence; sampled only in IDLE.
REQ-010 SHALL have port abort  input  1  synchronous cancel; highest priority after reset.
REQ-011 SHALL have port x_out  output  3  registered code symbol to the lock's x input.
REQ-012 SHALL have port y_in  input  1  lock's unlock indication.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse when an attempt series finishes.
REQ-015 SHALL have port unlocked  output  1  result flag, held from done until next accepted start.
REQ-016 SHALL have port fail  output  1  result flag, held from done until next accepted start.

Function
REQ-017 SHALL implement states IDLE, SEND1, SEND2, SEND3, WAIT, GAP, FIN.
REQ-018 SHALL, on a clock edge in IDLE with start=1, go to SEND1, clear unlocked/fail, and load the try counter with 1.
REQ-019 SHALL drive x_out=C1 in SEND1, C2 in SEND2, C3 in SEND3, IDLE_SYM in all other states, all registered.
REQ-020 SHALL advance SEND1->SEND2->SEND3->WAIT on consecutive edges and clear the wait counter on entering WAIT.
REQ-021 SHALL sample y_in on each edge in WAIT; y_in=1 -> FIN with unlocked=1.
REQ-022 SHALL, in WAIT with y_in=0 and wait counter = WAIT_CYCLES-1, go to GAP if tries < MAX_TRIES, else go to FIN with fail=1; otherwise increment the wait counter.
REQ-023 SHALL hold GAP for exactly one cycle with x_out=IDLE_SYM, increment tries, and then go to SEND1.
REQ-024 SHALL assert done for the single FIN cycle and then return to IDLE.
REQ-025 SHALL ignore start outside IDLE and ignore y_in outside WAIT.
REQ-026 SHALL, on abort=1 in any state, go to IDLE next edge with x_out=IDLE_SYM, with no done pulse and unlocked/fail unchanged.
REQ-027 SHALL give priority to y_in=1 over timeout when both occur on the same WAIT edge.
REQ-028 SHALL size the wait counter at 4 bits and the try counter at 3 bits, with no wrap in legal parameter ranges.
REQ-029 SHALL, against the companion lock, see y_in on the second WAIT sample, with the first C1 cycle k+1 after start at edge k and done high in cycle k+6.

Reset
REQ-030 SHALL, while reset=1, force IDLE, x_out=IDLE_SYM, busy=0, done=0, unlocked=0, fail=0, and both counters to 0.
REQ-031 SHALL, when reset is asserted mid-sequence, discard the attempt and emit no done pulse.

Structure
REQ-032 SHALL define state encodings as localparams within the module; no shared package is needed.
REQ-033 SHALL be a single module with no sub-modules; the testbench instantiates it with the companion digital lock as DUT pair.

Verification
REQ-034 SHALL cover: start at edge k, lock connected -> x_out 011,111,101 in cycles k+1..k+3, done=1 and unlocked=1 in cycle k+6, fail=0.
REQ-035 SHALL cover: y_in tied 0 with MAX_TRIES=3 and WAIT_CYCLES=4 -> three C1/C2/C3 bursts separated by 4 WAIT + 1 GAP cycles, then done=1 and fail=1.
REQ-036 SHALL cover: y_in 0 on the first attempt and driven 1 during the second WAIT -> unlocked=1 with exactly two bursts.
REQ-037 SHALL cover: abort during SEND2 -> next cycle x_out=000 and busy=0, no done pulse, and a following start runs normally.
REQ-038 SHALL cover: reset pulse in WAIT -> all outputs 0 and x_out=000 immediately; start held high during busy -> no extra sequence after done.
